// File: rtl/wb_scheduler.sv
// Writeback scheduler: arbitrates the single register-file write port between
// the ALU result path and an in-order queue of variable-latency load returns.
module wb_scheduler #(
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [63:0]               alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [4:0]                mem_rd,
    input  logic [63:0]               mem_data,
    output logic                      mem_ready,
    output logic                      RegWrite,
    output logic [4:0]                WriteRegister,
    output logic [63:0]               WriteData,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [4:0]      rd_mem   [LQ_DEPTH];
    logic [63:0]     data_mem [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [SW-1:0]   starve_reg, starve_next;
    logic [LQ_DEPTH-1:0] match;
    logic            hazard, empty, full, push, pop, grant_alu;
    logic [4:0]      grant_rd;
    logic [63:0]     grant_data;

    // An entry takes part in the hazard check only while it lies between the
    // read pointer and the current occupancy.
    generate
        for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_match
            logic [PW-1:0] offset;
            assign offset    = PW'(gi) - rd_ptr_reg;
            assign match[gi] = ({1'b0, offset} < count_reg) && (rd_mem[gi] == alu_rd);
        end
    endgenerate

    assign hazard    = alu_valid && (alu_rd != 5'd31) && (|match);
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(LQ_DEPTH));
    assign alu_ready = !reset && (state_reg == NORMAL) && !hazard;
    assign mem_ready = !reset && !full;
    assign grant_alu = alu_valid && alu_ready;
    assign pop       = !grant_alu && !empty;
    assign push      = mem_valid && mem_ready;
    assign lq_count  = count_reg;

    always_comb begin
        grant_rd   = alu_rd;
        grant_data = alu_data;
        if (!grant_alu) begin
            grant_rd   = rd_mem[rd_ptr_reg];
            grant_data = data_mem[rd_ptr_reg];
        end
    end

    always_comb begin
        starve_next = starve_reg;
        state_next  = state_reg;
        if (pop)
            starve_next = '0;
        else if (!empty && (starve_reg != SW'(STARVE_LIMIT)))
            starve_next = starve_reg + SW'(1);
        case (state_reg)
            NORMAL:  if (starve_next == SW'(STARVE_LIMIT)) state_next = DRAIN;
            DRAIN:   if (pop) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    // Queue storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= mem_rd;
            data_mem[wr_ptr_reg] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            starve_reg    <= '0;
            state_reg     <= NORMAL;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg  <= count_reg + CW'(push) - CW'(pop);
            starve_reg <= starve_next;
            state_reg  <= state_next;
            if (grant_alu || pop) begin
                RegWrite      <= (grant_rd != 5'd31);
                WriteRegister <= grant_rd;
                WriteData     <= grant_data;
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

endmodule
